// File: rtl/polar_pkg.sv
// Shared types and defaults for the polar SC leaf scheduler.
package polar_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_CAPT,
    S_OUT
  } state_e;

  localparam int unsigned PE_LAT_DEF = 2;

endpackage

// File: rtl/polar_leaf_sched_if.sv
// Scheduler-side bus: upstream LLR request, leaf PE issue/result, partial sums, frame output.
interface polar_leaf_sched_if #(
  parameter int unsigned N = 32
);
  localparam int unsigned IW = $clog2(N/2);

  logic          llr_req_o;
  logic [IW-1:0] llr_idx_o;
  logic          llr_vld_i;
  logic          pe_en_o;
  logic [1:0]    pe_frozen_o;
  logic          pe_f_i;
  logic          pe_g_i;
  logic          ps_vld_o;
  logic [IW-1:0] ps_idx_o;
  logic [1:0]    ps_o;
  logic          out_vld_o;
  logic          out_rdy_i;
  logic [N-1:0]  bits_o;

  modport master (
    output llr_req_o, llr_idx_o, pe_en_o, pe_frozen_o, ps_vld_o, ps_idx_o, ps_o,
           out_vld_o, bits_o,
    input  llr_vld_i, pe_f_i, pe_g_i, out_rdy_i
  );

  modport slave (
    input  llr_req_o, llr_idx_o, pe_en_o, pe_frozen_o, ps_vld_o, ps_idx_o, ps_o,
           out_vld_o, bits_o,
    output llr_vld_i, pe_f_i, pe_g_i, out_rdy_i
  );
endinterface

// File: rtl/polar_leaf_sched.sv
// Leaf-pair sequencer for a shared radix-4 polar SC leaf PE.
// Optional: define POLAR_FROZEN_SKIP_EN to bypass REQ/WAIT for fully frozen pairs.
module polar_leaf_sched
  import polar_pkg::*;
#(
  parameter int unsigned bitwidth = 7,
  parameter int unsigned N        = 32,
  parameter int unsigned PE_LAT   = PE_LAT_DEF
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               start_i,
  input  logic [N-1:0]       frozen_i,
  output logic               busy_o,
  polar_leaf_sched_if.master io
);

  localparam int unsigned IW = $clog2(N/2);
  localparam int unsigned CW = $clog2(PE_LAT + 1);
  localparam logic [IW-1:0] LAST_K = IW'(N/2 - 1);

  if (N < 4 || PE_LAT < 1 || bitwidth < 1) begin : g_bad_cfg
    $error("polar_leaf_sched: invalid parameter set");
  end

  state_e        r_state, w_next;
  logic [IW-1:0] r_k;
  logic [N-1:0]  r_frozen, r_bits;
  logic [CW-1:0] r_cnt;
  logic          r_f, r_g;

  logic [IW:0]   w_lo;
  logic [1:0]    w_frz;
  logic          w_b0, w_b1, w_last;

  // w_frz[0] is frozen[2k] (F position), w_frz[1] is frozen[2k+1] (G position)
  assign w_lo   = {r_k, 1'b0};
  assign w_frz  = r_frozen[w_lo +: 2];
  assign w_b0   = r_f & ~w_frz[0];
  assign w_b1   = r_g & ~w_frz[1];
  assign w_last = (r_k == LAST_K);

`ifdef POLAR_FROZEN_SKIP_EN
  logic [IW:0] w_lo_nx;
  logic        w_nx_skip;
  assign w_lo_nx   = {r_k + IW'(1), 1'b0};
  assign w_nx_skip = &r_frozen[w_lo_nx +: 2];
`endif

  assign busy_o         = (r_state != S_IDLE);
  assign io.llr_idx_o   = busy_o ? r_k : '0;
  assign io.pe_frozen_o = busy_o ? {w_frz[0], w_frz[1]} : '0;
  assign io.bits_o      = r_bits;

  always_comb begin
    w_next       = r_state;
    io.llr_req_o = 1'b0;
    io.pe_en_o   = 1'b0;
    io.ps_vld_o  = 1'b0;
    io.ps_idx_o  = '0;
    io.ps_o      = '0;
    io.out_vld_o = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (start_i) begin
`ifdef POLAR_FROZEN_SKIP_EN
          w_next = (&frozen_i[1:0]) ? S_CAPT : S_REQ;
`else
          w_next = S_REQ;
`endif
        end
      end
      S_REQ: begin
        io.llr_req_o = 1'b1;
        if (io.llr_vld_i) begin
          io.pe_en_o = 1'b1;
          w_next     = S_WAIT;
        end
      end
      S_WAIT: begin
        if (r_cnt == '0) w_next = S_CAPT;
      end
      S_CAPT: begin
        io.ps_vld_o = 1'b1;
        io.ps_idx_o = r_k;
        io.ps_o     = {w_b0 ^ w_b1, w_b1};
        if (w_last) begin
          w_next = S_OUT;
        end else begin
`ifdef POLAR_FROZEN_SKIP_EN
          w_next = w_nx_skip ? S_CAPT : S_REQ;
`else
          w_next = S_REQ;
`endif
        end
      end
      S_OUT: begin
        io.out_vld_o = 1'b1;
        if (io.out_rdy_i) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state  <= S_IDLE;
      r_k      <= '0;
      r_frozen <= '0;
      r_bits   <= '0;
      r_cnt    <= '0;
      r_f      <= 1'b0;
      r_g      <= 1'b0;
    end else begin
      r_state <= w_next;
      unique case (r_state)
        S_IDLE: begin
          if (start_i) begin
            r_frozen <= frozen_i;
            r_bits   <= '0;
            r_k      <= '0;
          end
        end
        S_REQ: begin
          if (io.llr_vld_i) r_cnt <= CW'(PE_LAT - 1);
        end
        S_WAIT: begin
          if (r_cnt == '0) begin
            r_f <= io.pe_f_i;
            r_g <= io.pe_g_i;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        // Skipped pairs reuse stale r_f/r_g; the frozen mask forces both bits to 0.
        S_CAPT: begin
          r_bits[w_lo +: 2] <= {w_b1, w_b0};
          if (!w_last) r_k <= r_k + IW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_polar_leaf_sched.sv
// Randomized self-checking bench for polar_leaf_sched against a per-frame schedule model.
module tb_polar_leaf_sched;

  localparam int unsigned N      = 32;
  localparam int unsigned PE_LAT = 2;
  localparam int unsigned NP     = N / 2;
  localparam int unsigned IW     = $clog2(NP);
  localparam int unsigned MAXC   = 512;

`ifdef POLAR_FROZEN_SKIP_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_ni = 1'b0;
  logic         start_i = 1'b0;
  logic [N-1:0] frozen_i = '0;
  logic         busy_o;

  polar_leaf_sched_if #(.N(N)) bus ();

  polar_leaf_sched #(
    .bitwidth(7),
    .N(N),
    .PE_LAT(PE_LAT)
  ) dut (
    .clk_i(clk),
    .rst_ni(rst_ni),
    .start_i(start_i),
    .frozen_i(frozen_i),
    .busy_o(busy_o),
    .io(bus.master)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Stimulus knobs per pair
  int stall[NP];
  bit fv[NP], gv[NP];

  // Schedule model, indexed by cycle after start (start accepted in cycle 0)
  bit   e_req[MAXC], e_en[MAXC], e_ps[MAXC], e_res[MAXC];
  int   e_k[MAXC], e_res_k[MAXC];
  int   en_c[NP];
  int   co;
  logic [N-1:0] exp_bits;
  logic [1:0]   exp_ps[NP];

  task automatic chk(input string nm, input int c, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @cycle %0d: got %0h expected %0h", nm, c, act, exp);
    end
  endtask

  task automatic build(input logic [N-1:0] mask);
    int c;
    for (int i = 0; i < MAXC; i++) begin
      e_req[i] = 0; e_en[i] = 0; e_ps[i] = 0; e_res[i] = 0; e_k[i] = NP - 1; e_res_k[i] = 0;
    end
    exp_bits = '0;
    c = 1;
    for (int k = 0; k < NP; k++) begin
      bit b0, b1;
      b0 = mask[2*k]   ? 1'b0 : fv[k];
      b1 = mask[2*k+1] ? 1'b0 : gv[k];
      exp_bits[2*k]   = b0;
      exp_bits[2*k+1] = b1;
      exp_ps[k] = {b0 ^ b1, b1};
      if (SKIP && mask[2*k] && mask[2*k+1]) begin
        en_c[k] = -1;
        e_k[c] = k; e_ps[c] = 1;
        c++;
      end else begin
        for (int s = 0; s <= stall[k]; s++) begin
          e_req[c+s] = 1; e_k[c+s] = k;
        end
        en_c[k] = c + stall[k];
        e_en[en_c[k]] = 1;
        for (int w = 1; w <= int'(PE_LAT); w++) e_k[en_c[k]+w] = k;
        e_res[en_c[k]+PE_LAT] = 1;
        e_res_k[en_c[k]+PE_LAT] = k;
        c = en_c[k] + PE_LAT + 1;
        e_k[c] = k; e_ps[c] = 1;
        c++;
      end
    end
    co = c;
  endtask

  task automatic chk_all_zero(input string nm, input int c);
    chk({nm, ".busy"}, c, busy_o, 0);
    chk({nm, ".llr_req"}, c, bus.llr_req_o, 0);
    chk({nm, ".llr_idx"}, c, bus.llr_idx_o, 0);
    chk({nm, ".pe_en"}, c, bus.pe_en_o, 0);
    chk({nm, ".pe_frozen"}, c, bus.pe_frozen_o, 0);
    chk({nm, ".ps_vld"}, c, bus.ps_vld_o, 0);
    chk({nm, ".ps_idx"}, c, bus.ps_idx_o, 0);
    chk({nm, ".ps"}, c, bus.ps_o, 0);
    chk({nm, ".out_vld"}, c, bus.out_vld_o, 0);
    chk({nm, ".bits"}, c, bus.bits_o, 0);
  endtask

  // Runs one frame; the model schedule drives llr_vld/PE results and judges every cycle.
  task automatic run_frame(input logic [N-1:0] mask, input int rdy_delay, input int abort_at,
                           input bit start_in_out, output int first_out, output int req_cnt,
                           output logic [N-1:0] bits_seen, output logic [1:0] last_ps);
    int last_c;
    build(mask);
    first_out = -1; req_cnt = 0; bits_seen = '0; last_ps = '0;
    @(negedge clk);
    frozen_i = mask;
    start_i  = 1'b1;
    last_c = co + rdy_delay + 1;
    for (int c = 1; c <= last_c; c++) begin
      int  ek;
      bit  ebusy, eout;
      @(negedge clk);
      frozen_i = N'($urandom);
      start_i  = (start_in_out && c >= co && c <= co + rdy_delay) ? 1'($urandom) : 1'b0;
      bus.llr_vld_i = e_req[c] ? e_en[c] : 1'($urandom);
      bus.pe_f_i    = e_res[c] ? fv[e_res_k[c]] : 1'($urandom);
      bus.pe_g_i    = e_res[c] ? gv[e_res_k[c]] : 1'($urandom);
      bus.out_rdy_i = (c >= co) ? (c >= co + rdy_delay) : 1'($urandom);
      #1;
      if (abort_at >= 0 && c == abort_at + 1) begin
        chk_all_zero("abort", c);
        rst_ni = 1'b1;
        return;
      end
      ek    = (c < co) ? e_k[c] : NP - 1;
      ebusy = (c < last_c);
      eout  = (c >= co) && ebusy;
      chk("busy", c, busy_o, ebusy);
      chk("llr_req", c, bus.llr_req_o, e_req[c]);
      chk("pe_en", c, bus.pe_en_o, e_en[c]);
      chk("ps_vld", c, bus.ps_vld_o, e_ps[c]);
      chk("out_vld", c, bus.out_vld_o, eout);
      if (ebusy) begin
        chk("llr_idx", c, bus.llr_idx_o, ek);
        chk("pe_frozen", c, bus.pe_frozen_o, {mask[2*ek], mask[2*ek+1]});
      end
      if (e_ps[c]) begin
        chk("ps_idx", c, bus.ps_idx_o, ek);
        chk("ps", c, bus.ps_o, exp_ps[ek]);
      end
      if (eout) chk("bits", c, bus.bits_o, exp_bits);
      if (bus.out_vld_o && first_out < 0) begin
        first_out = c;
        bits_seen = bus.bits_o;
      end
      if (bus.ps_vld_o) last_ps = bus.ps_o;
      req_cnt += int'(bus.llr_req_o);
      if (abort_at == c) rst_ni = 1'b0;
    end
  endtask

  task automatic randomize_pairs(input int max_stall);
    for (int k = 0; k < NP; k++) begin
      stall[k] = int'($urandom_range(max_stall, 0));
      fv[k] = 1'($urandom);
      gv[k] = 1'($urandom);
    end
  endtask

  initial begin
    int           fo, rq;
    logic [N-1:0] bs, m;
    logic [1:0]   lp;

    bus.llr_vld_i = 1'b0;
    bus.pe_f_i    = 1'b0;
    bus.pe_g_i    = 1'b0;
    bus.out_rdy_i = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk_all_zero("reset", 0);
    rst_ni = 1'b1;
    @(negedge clk);

    // Unfrozen frame, f=1 g=0, no stalls
    for (int k = 0; k < NP; k++) begin stall[k] = 0; fv[k] = 1; gv[k] = 0; end
    run_frame('0, 0, -1, 0, fo, rq, bs, lp);
    chk("t1.out_cycle", 0, fo, 65);
    chk("t1.bits", 0, bs, 32'h5555_5555);
    chk("t1.ps", 0, lp, 2'b10);
    chk("t1.req_cycles", 0, rq, 16);

    // Fully frozen frame, PE returns 1,1
    for (int k = 0; k < NP; k++) begin stall[k] = 0; fv[k] = 1; gv[k] = 1; end
    run_frame('1, 0, -1, 0, fo, rq, bs, lp);
    chk("t2.bits", 0, bs, 0);
    chk("t2.ps", 0, lp, 0);
    chk("t2.out_cycle", 0, fo, SKIP ? 17 : 65);
    chk("t2.req_cycles", 0, rq, SKIP ? 0 : 16);

    // Three-cycle LLR stall on pair 5
    randomize_pairs(0);
    stall[5] = 3;
    run_frame('0, 0, -1, 0, fo, rq, bs, lp);
    chk("t3.out_cycle", 0, fo, 68);
    chk("t3.en5", 0, en_c[5], 24);

    // Output back-pressure with ignored start pulses
    randomize_pairs(2);
    run_frame(N'($urandom), 10, -1, 1, fo, rq, bs, lp);
    @(negedge clk);
    #1;
    chk("t4.idle_after", 0, busy_o, 0);

    // Reset during pair 7 WAIT, then a fresh frame
    randomize_pairs(2);
    m = N'($urandom);
    m[15] = 1'b0;
    build(m);
    run_frame(m, 0, en_c[7] + 1, 0, fo, rq, bs, lp);
    randomize_pairs(1);
    run_frame(N'($urandom), 1, -1, 0, fo, rq, bs, lp);

    // Random frames
    for (int f = 0; f < 6; f++) begin
      randomize_pairs(3);
      run_frame(N'($urandom), int'($urandom_range(4, 0)), -1, 1'($urandom), fo, rq, bs, lp);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
